// File: rtl/m4sram_xpose_ctrl_if.sv
// Bundle of stream-in, stream-out and SRAM-side signals for the 4x4 transpose sequencer.
interface m4sram_xpose_ctrl_if #(
    parameter int unsigned DW = 64
);
    logic                in_valid;
    logic                in_ready;
    logic [3:0][DW-1:0]  din;
    logic                out_valid;
    logic                out_last;
    logic [3:0][DW-1:0]  dout;
    logic                we;
    logic [3:0][1:0]     addr;
    logic [3:0][DW-1:0]  d;
    logic [3:0][DW-1:0]  q;

    // Sequencer side
    modport slave (
        input  in_valid, din, q,
        output in_ready, out_valid, out_last, dout, we, addr, d
    );

    // Environment side: data source, data sink and SRAM
    modport master (
        output in_valid, din, q,
        input  in_ready, out_valid, out_last, dout, we, addr, d
    );
endinterface

// File: rtl/m4sram_xpose_ctrl.sv
// 4x4 reorder/transpose sequencer for the 4-bank M4SRAM scratch memory.
// Rows are written with a diagonal bank skew so that both a column and a row
// can be read back in one cycle without bank conflicts.
module m4sram_xpose_ctrl #(
    parameter int unsigned DW        = 64,
    parameter int unsigned TRANSPOSE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    m4sram_xpose_ctrl_if.slave    bus
);

    typedef enum logic {
        LOAD = 1'b0,
        READ = 1'b1
    } state_t;

    state_t      state;
    logic [1:0]  row;
    logic [1:0]  k;
    logic        rd_v;
    logic [1:0]  k_d;

    logic        accept;
    logic        rd_issue;

    assign accept   = !rst && (state == LOAD) && bus.in_valid;
    assign rd_issue = !rst && (state == READ);

    // Load/read sequencing plus the one-cycle read-pipeline tracking flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
            row   <= 2'd0;
            k     <= 2'd0;
            rd_v  <= 1'b0;
            k_d   <= 2'd0;
        end else begin
            rd_v <= (state == READ);
            k_d  <= k;
            case (state)
                LOAD: begin
                    if (bus.in_valid) begin
                        row <= row + 2'd1;
                        if (row == 2'd3) begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    k <= k + 2'd1;
                    if (k == 2'd3) begin
                        state <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    // SRAM command: skewed row write on accept, conflict-free read in READ, idle otherwise
    always_comb begin
        bus.in_ready = !rst && (state == LOAD);
        bus.we       = accept;
        bus.addr     = '0;
        bus.d        = '0;
        for (int b = 0; b < 4; b++) begin
            if (accept) begin
                bus.addr[b] = row;
                bus.d[b]    = bus.din[2'(2'(b) - row)];
            end else if (rd_issue) begin
                if (TRANSPOSE != 0) begin
                    bus.addr[b] = 2'(2'(b) - k);
                end else begin
                    bus.addr[b] = k;
                end
            end
        end
    end

    // Output lane rotation undoes the bank skew; data is zeroed when not valid
    always_comb begin
        bus.out_valid = rd_v && !rst;
        bus.out_last  = rd_v && !rst && (k_d == 2'd3);
        bus.dout      = '0;
        for (int j = 0; j < 4; j++) begin
            bus.dout[j] = bus.out_valid ? bus.q[2'(2'(j) + k_d)] : DW'(0);
        end
    end

endmodule

// File: tb/tb_m4sram_xpose_ctrl.sv
// Directed bench: one transpose-mode and one row-mode sequencer fed the same
// stimulus, each with its own behavioural 4-bank SRAM.
module tb_m4sram_xpose_ctrl;

    typedef logic [3:0][63:0] beat_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [3:0][63:0]  din;
    int                cyc = 0;

    int                tests = 0;
    int                fails = 0;

    m4sram_xpose_ctrl_if #(.DW(64)) bt ();
    m4sram_xpose_ctrl_if #(.DW(64)) br ();

    assign bt.in_valid = in_valid;
    assign br.in_valid = in_valid;
    assign bt.din      = din;
    assign br.din      = din;

    m4sram_xpose_ctrl #(.DW(64), .TRANSPOSE(1)) dut_t (.clk(clk), .rst(rst), .bus(bt));
    m4sram_xpose_ctrl #(.DW(64), .TRANSPOSE(0)) dut_r (.clk(clk), .rst(rst), .bus(br));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM models: shared WE; read data registered, held on write cycles
    logic [63:0] mem_t [4][4];
    logic [63:0] mem_r [4][4];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (bt.we) mem_t[b][bt.addr[b]] <= bt.d[b];
            else       bt.q[b] <= mem_t[b][bt.addr[b]];
            if (br.we) mem_r[b][br.addr[b]] <= br.d[b];
            else       br.q[b] <= mem_r[b][br.addr[b]];
        end
    end

    // Output capture on the falling edge
    beat_t qt[$];
    beat_t qr[$];
    logic  lt[$];
    logic  lr[$];
    int    ct[$];
    always @(negedge clk) begin
        if (!rst) begin
            if (bt.out_valid) begin
                qt.push_back(bt.dout);
                lt.push_back(bt.out_last);
                ct.push_back(cyc);
            end
            if (br.out_valid) begin
                qr.push_back(br.dout);
                lr.push_back(br.out_last);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one beat of frame 'base' row r and hold it until accepted
    task automatic send_beat(input logic [63:0] base, input int r, output int acc);
        bit ok;
        int waited;
        ok     = 1'b0;
        waited = 0;
        acc    = -1;
        in_valid = 1'b1;
        for (int c = 0; c < 4; c++) din[c] = base + 64'(4 * r + c);
        while (!ok && waited < 20) begin
            #1;
            if (bt.in_ready) begin
                ok  = 1'b1;
                acc = cyc;
                check($sformatf("we r%0d", r), 64'(bt.we), 64'd1);
                check($sformatf("addr r%0d", r), 64'(bt.addr), 64'({4{2'(r)}}));
                for (int b = 0; b < 4; b++)
                    check($sformatf("d%0d r%0d", b, r), bt.d[b], base + 64'(4 * r + ((b - r) & 3)));
            end
            @(posedge clk);
            #1;
            waited++;
        end
        in_valid = 1'b0;
        if (!ok) check($sformatf("accept_timeout r%0d", r), 64'd0, 64'd1);
    endtask

    // One LOAD cycle with no input: SRAM sees a harmless dummy read of address 0
    task automatic gap_cycle();
        in_valid = 1'b0;
        #1;
        check("idle we", 64'(bt.we), 64'd0);
        check("idle addr", 64'(bt.addr), 64'd0);
        check("idle d0", bt.d[0], 64'd0);
        check("idle d3", bt.d[3], 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [63:0] base, input bit gapped, output int acc3);
        int a;
        for (int r = 0; r < 4; r++) begin
            send_beat(base, r, a);
            if (gapped && r < 3) gap_cycle();
        end
        acc3 = a;
    endtask

    // Pop 4 beats from both sinks and compare against the hand-derived frame
    task automatic check_frame(input logic [63:0] base, input int acc3);
        beat_t bt_b, br_b;
        logic  l_t, l_r;
        int    c;
        for (int k = 0; k < 4; k++) begin
            if (qt.size() == 0 || qr.size() == 0) begin
                check($sformatf("missing beat k%0d base %0h", k, base), 64'd0, 64'd1);
                return;
            end
            bt_b = qt.pop_front();
            br_b = qr.pop_front();
            l_t  = lt.pop_front();
            l_r  = lr.pop_front();
            c    = ct.pop_front();
            check($sformatf("beat cycle k%0d", k), 64'(c), 64'(acc3 + 2 + k));
            for (int j = 0; j < 4; j++) begin
                check($sformatf("xpose k%0d j%0d", k, j), bt_b[j], base + 64'(4 * j + k));
                check($sformatf("row k%0d j%0d", k, j), br_b[j], base + 64'(4 * k + j));
            end
            check($sformatf("last xpose k%0d", k), 64'(l_t), 64'(k == 3));
            check($sformatf("last row k%0d", k), 64'(l_r), 64'(k == 3));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc3, acc3b, acc_b0, a;

        rst      = 1'b1;
        in_valid = 1'b1;
        din      = '0;
        #1;
        // Reset hold with IN_VALID asserted
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            check($sformatf("rst in_ready %0d", i), 64'(bt.in_ready), 64'd0);
            check($sformatf("rst we %0d", i), 64'(bt.we), 64'd0);
            check($sformatf("rst out_valid %0d", i), 64'(bt.out_valid | br.out_valid), 64'd0);
            check($sformatf("rst out_last %0d", i), 64'(bt.out_last | br.out_last), 64'd0);
            check($sformatf("rst addr %0d", i), 64'(bt.addr), 64'd0);
            check($sformatf("rst dout0 %0d", i), bt.dout[0], 64'd0);
        end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        idle(1);
        check("in_ready after reset", 64'(bt.in_ready), 64'd1);

        // Back-to-back frame
        send_frame(64'h100, 1'b0, acc3);
        idle(8);
        check_frame(64'h100, acc3);

        // Gapped frame gives identical output
        send_frame(64'h100, 1'b1, acc3);
        idle(8);
        check_frame(64'h100, acc3);

        // Second frame held waiting during READ, accepted right after read k=3
        send_frame(64'h100, 1'b0, acc3);
        send_beat(64'h200, 0, acc_b0);
        check("frame2 accept cycle", 64'(acc_b0), 64'(acc3 + 5));
        for (int r = 1; r < 4; r++) send_beat(64'h200, r, acc3b);
        idle(8);
        check_frame(64'h100, acc3);
        check_frame(64'h200, acc3b);

        // Mid-frame reset discards the partial load
        send_beat(64'h300, 0, a);
        send_beat(64'h300, 1, a);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(10);
        check("no output after mid reset", 64'(qt.size() + qr.size()), 64'd0);
        send_frame(64'h300, 1'b0, acc3);
        idle(8);
        check_frame(64'h300, acc3);
        check("queues drained", 64'(qt.size() + qr.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
